// File: rtl/k12a_pc_pkg.sv
// Shared types and helpers for the k12a program-counter unit.
package k12a_pc_pkg;

  typedef enum logic [2:0] {
    PC_NOP,
    PC_STORE,
    PC_CALL,
    PC_RET,
    PC_REL,
    PC_INC
  } pc_cmd_e;

  localparam int SEXT_MAX_W = 64;

  // Strobes can overlap; the highest-priority one wins and the rest are dropped.
  function automatic pc_cmd_e pc_cmd_decode(input logic store, input logic call,
                                            input logic ret, input logic rel,
                                            input logic inc);
    if (store)     return PC_STORE;
    else if (call) return PC_CALL;
    else if (ret)  return PC_RET;
    else if (rel)  return PC_REL;
    else if (inc)  return PC_INC;
    else           return PC_NOP;
  endfunction

  // Sign-extends the low off_w bits of off; callers truncate to their own width.
  function automatic logic [SEXT_MAX_W-1:0] sext_offset(input logic [SEXT_MAX_W-1:0] off,
                                                         input int off_w);
    logic signed [SEXT_MAX_W-1:0] shifted;
    shifted = signed'(off << (SEXT_MAX_W - off_w));
    return shifted >>> (SEXT_MAX_W - off_w);
  endfunction

endpackage

// File: rtl/k12a_pc_if.sv
// Command strobes from the control unit and status returned by the PC unit.
interface k12a_pc_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int OFF_W = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             pc_load_n;
  logic             ra_load_n;
  logic             pc_store;
  logic             pc_inc;
  logic             pc_rel;
  logic [OFF_W-1:0] offset;
  logic             call;
  logic             ret;
  logic             err_clear;

  logic [WIDTH-1:0] pc;
  logic [CNT_W-1:0] ras_count;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_overflow;
  logic             ras_underflow;

  modport master (
    output pc_load_n, ra_load_n, pc_store, pc_inc, pc_rel, offset, call, ret, err_clear,
    input  pc, ras_count, ras_empty, ras_full, ras_overflow, ras_underflow
  );

  modport slave (
    input  pc_load_n, ra_load_n, pc_store, pc_inc, pc_rel, offset, call, ret, err_clear,
    output pc, ras_count, ras_empty, ras_full, ras_overflow, ras_underflow
  );

endinterface

// File: rtl/k12a_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
module k12a_ras #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow_evt,
  output logic             underflow_evt
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, top_ptr;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  assign full          = (count_q == CNT_W'(DEPTH));
  assign empty         = (count_q == '0);
  assign count         = count_q;
  assign top_ptr       = wr_ptr_q - PTR_W'(1);
  assign top           = mem_q[top_ptr];
  assign do_pop        = pop && !push && !empty;
  assign overflow_evt  = push && full;
  assign underflow_evt = pop && !push && empty;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (!full) count_d = count_q + CNT_W'(1);
    end else if (do_pop) begin
      wr_ptr_d = top_ptr;
      count_d  = count_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is left out of reset; count_q alone decides which entries are valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/k12a_pc_unit.sv
// Program counter with relative branch, call/return via a hardware RAS,
// and a tri-state drive onto the shared address bus.
module k12a_pc_unit
  import k12a_pc_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter int               DEPTH    = 4,
  parameter int               OFF_W    = 8,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  inout  wire  [WIDTH-1:0] addr_bus,
  k12a_pc_if.slave         ctl
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  pc_cmd_e          cmd;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] offset_ext;
  logic [WIDTH-1:0] ras_top;
  logic [WIDTH-1:0] bus_val;
  logic             bus_en;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             ras_push, ras_pop;
  logic             ras_full, ras_empty, ras_ovf_evt, ras_unf_evt;
  logic [CNT_W-1:0] ras_count;

  k12a_ras #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ras (
    .clock        (clock),
    .reset_n      (reset_n),
    .push         (ras_push),
    .pop          (ras_pop),
    .din          (pc_q),
    .top          (ras_top),
    .count        (ras_count),
    .full         (ras_full),
    .empty        (ras_empty),
    .overflow_evt (ras_ovf_evt),
    .underflow_evt(ras_unf_evt)
  );

  assign cmd        = pc_cmd_decode(ctl.pc_store, ctl.call, ctl.ret, ctl.pc_rel, ctl.pc_inc);
  assign offset_ext = WIDTH'(sext_offset(SEXT_MAX_W'(ctl.offset), OFF_W));

  always_comb begin
    pc_d     = pc_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    unique case (cmd)
      PC_STORE: pc_d = addr_bus;
      PC_CALL: begin
        ras_push = 1'b1;
        pc_d     = addr_bus;
      end
      PC_RET: begin
        ras_pop = 1'b1;
        if (!ras_empty) pc_d = ras_top;
      end
      PC_REL:  pc_d = pc_q + offset_ext;
      PC_INC:  pc_d = pc_q + WIDTH'(1);
      default: pc_d = pc_q;
    endcase
  end

  // A flag-setting event outranks err_clear in the same cycle.
  assign ovf_d = ras_ovf_evt | (ovf_q & ~ctl.err_clear);
  assign unf_d = ras_unf_evt | (unf_q & ~ctl.err_clear);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q  <= RESET_PC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // pc_load_n outranks ra_load_n, so only one source ever reaches the bus.
  always_comb begin
    bus_en  = 1'b1;
    bus_val = pc_q;
    if (ctl.pc_load_n) begin
      if (!ctl.ra_load_n) bus_val = ras_empty ? '0 : ras_top;
      else                bus_en  = 1'b0;
    end
  end

  assign addr_bus = bus_en ? bus_val : {WIDTH{1'bz}};

  assign ctl.pc            = pc_q;
  assign ctl.ras_count     = ras_count;
  assign ctl.ras_empty     = ras_empty;
  assign ctl.ras_full      = ras_full;
  assign ctl.ras_overflow  = ovf_q;
  assign ctl.ras_underflow = unf_q;

endmodule

// File: tb/tb_k12a_pc_unit.sv
// Self-checking bench for k12a_pc_unit: directed corner cases, then random
// command mixes compared against a queue-based behavioural model.
module tb_k12a_pc_unit;

  localparam int          WIDTH    = 16;
  localparam int          DEPTH    = 4;
  localparam int          OFF_W    = 8;
  localparam logic [15:0] RESET_PC = 16'h0100;

  logic        clock = 1'b0;
  logic        reset_n;
  wire  [15:0] addr_bus;
  logic        tb_bus_en;
  logic [15:0] tb_bus_val;

  assign addr_bus = tb_bus_en ? tb_bus_val : 16'hzzzz;

  k12a_pc_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OFF_W(OFF_W)) cif ();

  k12a_pc_unit #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .OFF_W(OFF_W), .RESET_PC(RESET_PC)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .addr_bus(addr_bus),
    .ctl     (cif)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: the stack is a queue whose back is the most recent push.
  logic [15:0] m_pc;
  logic [15:0] m_ras[$];
  logic        m_ovf, m_unf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    cif.pc_load_n = 1'b1;
    cif.ra_load_n = 1'b1;
    cif.pc_store  = 1'b0;
    cif.pc_inc    = 1'b0;
    cif.pc_rel    = 1'b0;
    cif.offset    = '0;
    cif.call      = 1'b0;
    cif.ret       = 1'b0;
    cif.err_clear = 1'b0;
    tb_bus_en     = 1'b0;
    tb_bus_val    = '0;
  endtask

  task automatic model_reset();
    m_pc = RESET_PC;
    m_ras.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  function automatic logic [15:0] m_top();
    return (m_ras.size() == 0) ? 16'h0000 : m_ras[$];
  endfunction

  task automatic model_edge();
    logic ovf_e, unf_e;
    int   t;
    ovf_e = 1'b0;
    unf_e = 1'b0;
    if (cif.pc_store) begin
      m_pc = tb_bus_val;
    end else if (cif.call) begin
      m_ras.push_back(m_pc);
      if (m_ras.size() > DEPTH) begin
        m_ras.delete(0);
        ovf_e = 1'b1;
      end
      m_pc = tb_bus_val;
    end else if (cif.ret) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else                  unf_e = 1'b1;
    end else if (cif.pc_rel) begin
      t    = int'(m_pc) + int'($signed(cif.offset));
      m_pc = t[15:0];
    end else if (cif.pc_inc) begin
      m_pc = m_pc + 16'd1;
    end
    if (cif.err_clear) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    m_ovf = m_ovf | ovf_e;
    m_unf = m_unf | unf_e;
  endtask

  task automatic check_status(input string tag);
    check({tag, ".pc"},    32'(cif.pc),            32'(m_pc));
    check({tag, ".cnt"},   32'(cif.ras_count),     32'(m_ras.size()));
    check({tag, ".empty"}, 32'(cif.ras_empty),     32'(m_ras.size() == 0));
    check({tag, ".full"},  32'(cif.ras_full),      32'(m_ras.size() == DEPTH));
    check({tag, ".ovf"},   32'(cif.ras_overflow),  32'(m_ovf));
    check({tag, ".unf"},   32'(cif.ras_underflow), 32'(m_unf));
  endtask

  // Inputs are set after a falling edge; the model steps with them, the DUT
  // samples them at the rising edge, and outputs are checked at the next fall.
  task automatic tick(input string tag);
    model_edge();
    @(posedge clock);
    @(negedge clock);
    check_status(tag);
    idle();
  endtask

  task automatic do_store(input logic [15:0] v);
    tb_bus_en    = 1'b1;
    tb_bus_val   = v;
    cif.pc_store = 1'b1;
    tick("store");
  endtask

  task automatic do_call(input logic [15:0] target, input string tag);
    tb_bus_en  = 1'b1;
    tb_bus_val = target;
    cif.call   = 1'b1;
    tick(tag);
  endtask

  task automatic do_ret(input string tag);
    cif.ret = 1'b1;
    tick(tag);
  endtask

  initial begin
    idle();
    model_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    check_status("reset");

    // Bus drive: pc onto the bus, then released so another driver owns it.
    cif.pc_load_n = 1'b0;
    #1 check("bus_pc_reset", 32'(addr_bus), 32'h0100);
    cif.pc_load_n = 1'b1;
    tb_bus_en  = 1'b1;
    tb_bus_val = 16'h5A3C;
    #1 check("bus_released", 32'(addr_bus), 32'h5A3C);
    idle();

    // Increment wrap and relative branches in both directions.
    do_store(16'hFFFF);
    cif.pc_inc = 1'b1;
    tick("inc_wrap");
    check("inc_wrap_const", 32'(cif.pc), 32'h0000);

    do_store(16'h0010);
    cif.pc_rel = 1'b1;
    cif.offset = 8'hF0;
    tick("rel_neg");
    check("rel_neg_const", 32'(cif.pc), 32'h0000);

    do_store(16'hFFF0);
    cif.pc_rel = 1'b1;
    cif.offset = 8'h7F;
    tick("rel_pos");
    check("rel_pos_const", 32'(cif.pc), 32'h006F);

    // Single call / return round trip.
    do_store(16'h1234);
    do_call(16'h4000, "call1");
    check("call1_pc_const", 32'(cif.pc), 32'h4000);
    check("call1_cnt_const", 32'(cif.ras_count), 32'd1);
    cif.ra_load_n = 1'b0;
    #1 check("bus_ra_top", 32'(addr_bus), 32'h1234);
    cif.ra_load_n = 1'b1;
    do_ret("ret1");
    check("ret1_pc_const", 32'(cif.pc), 32'h1234);
    check("ret1_empty_const", 32'(cif.ras_empty), 32'd1);

    // Overflow: five calls from pcs 1000..1400 into a 4-deep stack.
    do_store(16'h1000);
    for (int i = 0; i < 5; i++) begin
      do_call(16'h1000 + 16'((i + 1) * 16'h0100), "ovf_call");
      if (i == 3) check("ovf_not_yet", 32'(cif.ras_overflow), 32'd0);
    end
    check("ovf_set_const", 32'(cif.ras_overflow), 32'd1);
    check("ovf_cnt_const", 32'(cif.ras_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      do_ret("ovf_ret");
      check("ovf_ret_order", 32'(cif.pc), 32'h1400 - 32'(i * 16'h0100));
    end
    do_ret("unf_ret");
    check("unf_pc_hold", 32'(cif.pc), 32'h1100);
    check("unf_set_const", 32'(cif.ras_underflow), 32'd1);

    // Priority: store beats call and inc, stack untouched.
    do_call(16'h3000, "prio_pre");
    tb_bus_en    = 1'b1;
    tb_bus_val   = 16'h2222;
    cif.pc_store = 1'b1;
    cif.call     = 1'b1;
    cif.pc_inc   = 1'b1;
    tick("prio");
    check("prio_pc_const", 32'(cif.pc), 32'h2222);
    check("prio_cnt_const", 32'(cif.ras_count), 32'd1);
    do_ret("prio_ret");

    // err_clear loses to an underflow in the same cycle but clears overflow.
    cif.ret       = 1'b1;
    cif.err_clear = 1'b1;
    tick("clr_vs_unf");
    check("clr_vs_unf_const", 32'(cif.ras_underflow), 32'd1);
    check("clr_ovf_const", 32'(cif.ras_overflow), 32'd0);
    cif.err_clear = 1'b1;
    tick("clr_only");

    // Random command mixes, including overlapping strobes and bus reads.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        cif.pc_load_n = 1'b0;
        cif.ra_load_n = 1'($urandom_range(0, 1));
        #1 check("rnd_bus_pc", 32'(addr_bus), 32'(m_pc));
        idle();
      end else if ($urandom_range(0, 2) == 0) begin
        cif.ra_load_n = 1'b0;
        #1 check("rnd_bus_ra", 32'(addr_bus), 32'(m_top()));
        idle();
      end
      tb_bus_en     = 1'b1;
      tb_bus_val    = 16'($urandom);
      cif.offset    = 8'($urandom);
      cif.pc_store  = ($urandom_range(0, 9) == 0);
      cif.call      = ($urandom_range(0, 9) < 2);
      cif.ret       = ($urandom_range(0, 9) < 3);
      cif.pc_rel    = ($urandom_range(0, 9) < 3);
      cif.pc_inc    = ($urandom_range(0, 9) < 4);
      cif.err_clear = ($urandom_range(0, 9) == 0);
      tick("rnd");
    end

    // Asynchronous reset between edges after three pushes, with a flag set.
    cif.err_clear = 1'b1;
    tick("pre_rst_clr");
    for (int i = 0; i < DEPTH; i++) begin
      if (m_ras.size() > 0) do_ret("drain");
    end
    do_ret("pre_rst_unf");
    do_call(16'h5000, "pre_rst_call1");
    do_call(16'h6000, "pre_rst_call2");
    tb_bus_en  = 1'b1;
    tb_bus_val = 16'h7000;
    cif.call   = 1'b1;
    model_edge();
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_status("async_rst");
    check("async_rst_pc_const", 32'(cif.pc), 32'h0100);
    @(negedge clock);
    idle();
    reset_n = 1'b1;
    tick("post_rst_hold");
    do_call(16'h7777, "post_rst_call");
    do_ret("post_rst_ret");
    check("post_rst_ret_const", 32'(cif.pc), 32'h0100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
